pipo_write_arbiter: RTL

- Shares one N-bit parallel-in/parallel-out register (enable-gated D-type bank, async active-low reset) between M requesters.
- Round-robin arbitration; registers the winner's data, drives the bank's D and EN for exactly one cycle, then enforces a programmable hold gap before the next write.
- Sits between producer blocks and the shared PIPO register; the register's Q is consumed elsewhere.

---
 rtl/pipo_arb_pkg.sv | 18 +
 rtl/pipo_write_arbiter_rr_pick.sv | 36 +++
 rtl/pipo_write_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared types and constants for the PIPO write arbiter.
package pipo_arb_pkg;

   // Width of the post-write hold counter (HOLD range 0..15)
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // Index width for m requesters, never narrower than one bit
   function automatic int unsigned idx_w(input int unsigned m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/pipo_write_arbiter_rr_pick.sv
// Round-robin pick: first set request searching upward from the pointer, wrapping at M.
module rr_pick
   import pipo_arb_pkg::*;
#(
   parameter int unsigned M  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [M-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [M-1:0]  win,
   output logic [IW-1:0] win_id,
   output logic          valid
);

   logic [IW:0] cand;

   // Scan candidates ptr, ptr+1, ... modulo M and keep the first requester found
   always_comb begin
      win    = '0;
      win_id = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int k = 0; k < int'(M); k++) begin
         cand = (IW+1)'(ptr) + (IW+1)'(k);
         if (cand >= (IW+1)'(M)) begin
            cand = cand - (IW+1)'(M);
         end
         if (!valid && req[cand[IW-1:0]]) begin
            valid               = 1'b1;
            win_id              = cand[IW-1:0];
            win[cand[IW-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipo_write_arbiter.sv
// Round-robin arbiter sharing one PIPO register bank: one-cycle write pulse, then a hold gap.
module pipo_write_arbiter
   import pipo_arb_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter int unsigned M    = 4,
   parameter int unsigned HOLD = 2
) (
   input  logic                  CLK,
   input  logic                  n_Reset,
   input  logic [M-1:0]          req,
   input  logic [M*N-1:0]        wdata,
   output logic [M-1:0]          gnt,
   output logic [N-1:0]          reg_D,
   output logic                  reg_EN,
   output logic                  busy,
   output logic [$clog2(M)-1:0]  last_id
);

   localparam int unsigned IW = $clog2(M);
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'((HOLD > 0) ? HOLD - 1 : 0);

   state_t         state;
   state_t         next_state;
   logic [IW-1:0]  ptr;
   logic [CNT_W-1:0] cnt;

   logic [M-1:0]   pick_win;
   logic [IW-1:0]  pick_id;
   logic           pick_valid;
   logic [N-1:0]   sel_data;

   logic [M-1:0]   gnt_nxt;
   logic           en_nxt;
   logic           busy_nxt;

   rr_pick #(.M(M), .IW(IW)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .win    (pick_win),
      .win_id (pick_id),
      .valid  (pick_valid)
   );

   // Winner's write data
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < int'(M); i++) begin
         if (pick_id == IW'(i)) begin
            sel_data = wdata[i*N +: N];
         end
      end
   end

   // State register
   always_ff @(posedge CLK or negedge n_Reset) begin
      if (!n_Reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: arbitrate only in IDLE, single LOAD cycle, counted HOLD gap
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (pick_valid) next_state = S_LOAD;
         S_LOAD:  next_state = (HOLD > 0) ? S_HOLD : S_IDLE;
         S_HOLD:  if (cnt == '0) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state, registered below
   always_comb begin
      gnt_nxt  = '0;
      en_nxt   = 1'b0;
      busy_nxt = 1'b0;
      if (next_state == S_LOAD) begin
         gnt_nxt = pick_win;
         en_nxt  = 1'b1;
      end
      if (next_state != S_IDLE) begin
         busy_nxt = 1'b1;
      end
   end

   // Registered control outputs; reset drops reg_EN immediately, abandoning a write
   always_ff @(posedge CLK or negedge n_Reset) begin
      if (!n_Reset) begin
         gnt    <= '0;
         reg_EN <= 1'b0;
         busy   <= 1'b0;
      end else begin
         gnt    <= gnt_nxt;
         reg_EN <= en_nxt;
         busy   <= busy_nxt;
      end
   end

   // Capture winner data and id, advance the rotation pointer past the winner
   always_ff @(posedge CLK or negedge n_Reset) begin
      if (!n_Reset) begin
         reg_D   <= '0;
         last_id <= '0;
         ptr     <= '0;
      end else if (state == S_IDLE && pick_valid) begin
         reg_D   <= sel_data;
         last_id <= pick_id;
         ptr     <= (pick_id == IW'(M - 1)) ? '0 : pick_id + IW'(1);
      end
   end

   // Hold gap counter
   always_ff @(posedge CLK or negedge n_Reset) begin
      if (!n_Reset) begin
         cnt <= '0;
      end else if (state == S_LOAD) begin
         cnt <= HOLD_INIT;
      end else if (state == S_HOLD && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule
